stack_op_sequencer: RTL and testbench

- Command-driven controller that owns the push/pop port of the 8-bit hardware stack.
- Accepts one stack operation at a time over a valid/ready handshake: PUSH, POP, ADD, SUB or DUP.
- Sequences the stack strobes and performs the arithmetic.
- Returns the result, Z/S flags and an error code, so the CPU no longer hand-steps T0..T4 phases.

---
 rtl/stack_op_sequencer_if.sv | 21 ++
 rtl/stack_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_stack_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_op_sequencer_if.sv
// Command/response handshake between the CPU and the stack operation sequencer.
// master = CPU side, slave = sequencer side.
interface stack_op_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic [1:0] rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/stack_op_sequencer.sv
// Sequences push/pop strobes of the 8-bit hardware stack for PUSH/POP/ADD/SUB/DUP commands.
// Optional macro SEQ_SATURATE_EN: signed saturating ADD/SUB instead of modulo-256 wrap.
module stack_op_sequencer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic                 Clock,
   input  logic                 reset,
   stack_op_sequencer_if.slave  cmd,
   output logic                 stk_push,
   output logic                 stk_pop,
   output logic [7:0]           stk_din,
   input  logic [7:0]           stk_dout,
   output logic                 flag_z,
   output logic                 flag_s,
   output logic [CW-1:0]        count
);

   typedef enum logic [3:0] {
      IDLE, POP1, WAIT1, POP2, WAIT2, EXEC, PUSH1, PUSH2, DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_PUSH = 3'b000, OP_POP = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011, OP_DUP = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      ERR_OK = 2'b00, ERR_UNF = 2'b01, ERR_OVF = 2'b10, ERR_ILL = 2'b11
   } err_e;

   state_e        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [7:0]    a_q, a_d, b_q, b_d, res_q, res_d;
   err_e          err_q, err_d, acc_err;
   logic [CW-1:0] count_q, count_d;
   logic          flag_z_q, flag_z_d, flag_s_q, flag_s_d;
   logic [7:0]    alu_res;

   // Occupancy check made against the command still on the bus, before it is latched
   always_comb begin
      acc_err = ERR_OK;
      case (cmd.cmd_op)
         OP_PUSH:        if (count_q == CW'(DEPTH)) acc_err = ERR_OVF;
         OP_POP:         if (count_q == '0) acc_err = ERR_UNF;
         OP_ADD, OP_SUB: if (count_q < CW'(2)) acc_err = ERR_UNF;
         OP_DUP: begin
            if (count_q == '0)              acc_err = ERR_UNF;
            else if (count_q == CW'(DEPTH)) acc_err = ERR_OVF;
         end
         default:        acc_err = ERR_ILL;
      endcase
   end

`ifdef SEQ_SATURATE_EN
   logic [8:0] wide;
   // Sign-extended 9-bit result: top two bits disagree exactly on signed overflow
   always_comb begin
      wide = (op_q == OP_SUB) ? {a_q[7], a_q} - {b_q[7], b_q}
                              : {a_q[7], a_q} + {b_q[7], b_q};
      if (wide[8] != wide[7]) alu_res = wide[8] ? 8'h80 : 8'h7F;
      else                    alu_res = wide[7:0];
   end
`else
   always_comb alu_res = (op_q == OP_SUB) ? a_q - b_q : a_q + b_q;
`endif

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (cmd.cmd_valid)
                   state_d = (acc_err != ERR_OK)    ? DONE :
                             (cmd.cmd_op == OP_PUSH) ? PUSH1 : POP1;
         POP1:  state_d = WAIT1;
         WAIT1: state_d = (op_q == OP_POP) ? DONE : (op_q == OP_DUP) ? PUSH1 : POP2;
         POP2:  state_d = WAIT2;
         WAIT2: state_d = EXEC;
         EXEC:  state_d = PUSH1;
         PUSH1: state_d = (op_q == OP_DUP) ? PUSH2 : DONE;
         PUSH2: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd.cmd_ready = (state_q == IDLE);
      stk_pop       = (state_q == POP1) || (state_q == POP2);
      stk_push      = (state_q == PUSH1) || (state_q == PUSH2);
      stk_din       = ((state_q == PUSH1) || (state_q == PUSH2)) ? res_q : '0;
      cmd.rsp_valid = (state_q == DONE);
      cmd.rsp_data  = (state_q == DONE) ? res_q : '0;
      cmd.rsp_err   = (state_q == DONE) ? err_q : ERR_OK;
   end

   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      err_d    = err_q;
      count_d  = count_q;
      flag_z_d = flag_z_q;
      flag_s_d = flag_s_q;
      case (state_q)
         IDLE: if (cmd.cmd_valid) begin
            op_d  = cmd.cmd_op;
            err_d = acc_err;
            res_d = (acc_err == ERR_OK && cmd.cmd_op == OP_PUSH) ? cmd.cmd_data : '0;
         end
         POP1, POP2:   count_d = count_q - CW'(1);
         WAIT1: begin
            a_d   = stk_dout;
            res_d = stk_dout;
         end
         WAIT2:        b_d = stk_dout;
         EXEC: begin
            res_d    = alu_res;
            flag_z_d = (alu_res == '0);
            flag_s_d = alu_res[7];
         end
         PUSH1, PUSH2: count_d = count_q + CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         err_q    <= ERR_OK;
         count_q  <= '0;
         flag_z_q <= 1'b0;
         flag_s_q <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         err_q    <= err_d;
         count_q  <= count_d;
         flag_z_q <= flag_z_d;
         flag_s_q <= flag_s_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_s = flag_s_q;
   assign count  = count_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Randomized self-checking bench for stack_op_sequencer against a queue-based reference model.
module tb_stack_op_sequencer;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   logic          Clock = 1'b0;
   logic          reset;
   logic          stk_push, stk_pop;
   logic [7:0]    stk_din, stk_dout;
   logic          flag_z, flag_s;
   logic [CW-1:0] count;

   stack_op_sequencer_if bus();

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 Clock = ~Clock;

   stack_op_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .Clock    (Clock),
      .reset    (reset),
      .cmd      (bus),
      .stk_push (stk_push),
      .stk_pop  (stk_pop),
      .stk_din  (stk_din),
      .stk_dout (stk_dout),
      .flag_z   (flag_z),
      .flag_s   (flag_s),
      .count    (count)
   );

   // Behavioural hardware stack sharing the reset net; top of stack is the queue back
   logic [7:0] mem[$];
   always @(posedge Clock or posedge reset) begin
      if (reset) begin
         mem.delete();
         stk_dout <= '0;
      end else if (stk_push) begin
         if (mem.size() < DEPTH) mem.push_back(stk_din);
      end else if (stk_pop) begin
         if (mem.size() > 0) stk_dout <= mem.pop_back();
      end
   end

   // Reference model state
   int unsigned ref_q[$];
   bit          ref_z, ref_s;
   int unsigned last_data;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic int signed to_s8(input int unsigned v);
      return (v >= 128) ? int'(v) - 256 : int'(v);
   endfunction

   task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
      int unsigned exp_err, exp_data, exp_lat, exp_pop, exp_push;
      int unsigned got_lat, got_data, got_err, pop_m, push_m, din_bad, mism;
      int unsigned a, b;
      int signed   rs;
      exp_err = 0; exp_data = 0; exp_pop = 0; exp_push = 0; exp_lat = 1;
      case (op)
         3'd0: if (ref_q.size() == DEPTH) exp_err = 2;
               else begin
                  ref_q.push_back(data); exp_data = data;
                  exp_lat = 2; exp_push = 1 << 1;
               end
         3'd1: if (ref_q.size() < 1) exp_err = 1;
               else begin
                  exp_data = ref_q.pop_back();
                  exp_lat = 3; exp_pop = 1 << 1;
               end
         3'd2, 3'd3: if (ref_q.size() < 2) exp_err = 1;
               else begin
                  a = ref_q.pop_back();
                  b = ref_q.pop_back();
                  rs = (op == 3'd2) ? to_s8(a) + to_s8(b) : to_s8(a) - to_s8(b);
`ifdef SEQ_SATURATE_EN
                  if (rs > 127)  rs = 127;
                  if (rs < -128) rs = -128;
`endif
                  exp_data = int'(unsigned'(rs)) & 255;
                  ref_q.push_back(exp_data);
                  ref_z = (exp_data == 0);
                  ref_s = (exp_data >= 128);
                  exp_lat = 7; exp_pop = (1 << 1) | (1 << 3); exp_push = 1 << 6;
               end
         3'd4: if (ref_q.size() == 0) exp_err = 1;
               else if (ref_q.size() == DEPTH) exp_err = 2;
               else begin
                  exp_data = ref_q[ref_q.size() - 1];
                  ref_q.push_back(exp_data);
                  exp_lat = 5; exp_pop = 1 << 1; exp_push = (1 << 3) | (1 << 4);
               end
         default: exp_err = 3;
      endcase

      @(negedge Clock);
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      @(negedge Clock);
      bus.cmd_valid = 1'b0;
      got_lat = 0; got_data = 0; got_err = 0; pop_m = 0; push_m = 0; din_bad = 0;
      for (int k = 1; k <= 12 && got_lat == 0; k++) begin
         if (k > 1) @(negedge Clock);
         if (stk_pop) pop_m |= (1 << k);
         if (stk_push) begin
            push_m |= (1 << k);
            if (stk_din != exp_data[7:0]) din_bad++;
         end
         if (bus.rsp_valid) begin
            got_lat  = k;
            got_data = bus.rsp_data;
            got_err  = bus.rsp_err;
         end
      end
      last_data = got_data;
      check("rsp_latency", got_lat, exp_lat);
      check("rsp_err", got_err, exp_err);
      check("rsp_data", got_data, exp_data);
      check("pop_cycles", pop_m, exp_pop);
      check("push_cycles", push_m, exp_push);
      check("stk_din", din_bad, 0);

      @(negedge Clock);
      check("cmd_ready_after", bus.cmd_ready, 1);
      check("count", count, ref_q.size());
      check("flag_z", flag_z, ref_z);
      check("flag_s", flag_s, ref_s);
      mism = (mem.size() != ref_q.size()) ? 1 : 0;
      for (int i = 0; i < mem.size() && i < ref_q.size(); i++)
         if (mem[i] != ref_q[i][7:0]) mism++;
      check("stack_contents", mism, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r;
      logic [2:0]  op;
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_data  = '0;
      ref_z = 0; ref_s = 0; last_data = 0;
      repeat (2) @(negedge Clock);
      check("rst_stk_push", stk_push, 0);
      check("rst_stk_pop", stk_pop, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_count", count, 0);
      check("rst_flags", {flag_z, flag_s}, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      reset = 1'b0;

      // Directed scenarios
      do_cmd(3'd0, 8'd23);
      do_cmd(3'd0, 8'd5);
      do_cmd(3'd2, 8'd0);
      check("add_23_5", last_data, 28);
      do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd12);
      do_cmd(3'd0, 8'd12);
      do_cmd(3'd3, 8'd0);
      check("sub_12_12", last_data, 0);
      do_cmd(3'd0, 8'd3);
      do_cmd(3'd0, 8'd5);
      do_cmd(3'd3, 8'd0);
      check("sub_5_3", last_data, 2);
      while (ref_q.size() > 0) do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd1);
      do_cmd(3'd1, 8'd0);
      check("pop_one", last_data, 1);
      do_cmd(3'd1, 8'd0);
      do_cmd(3'd2, 8'd0);
      do_cmd(3'd4, 8'd0);
      for (int i = 0; i < DEPTH; i++) do_cmd(3'd0, 8'(i * 17 + 1));
      do_cmd(3'd0, 8'd99);
      do_cmd(3'd4, 8'd0);
      do_cmd(3'd6, 8'd0);
      do_cmd(3'd5, 8'd0);
      do_cmd(3'd7, 8'd0);
      while (ref_q.size() > 0) do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd1);
      do_cmd(3'd0, 8'd127);
      do_cmd(3'd2, 8'd0);
`ifdef SEQ_SATURATE_EN
      check("add_127_1", last_data, 8'h7F);
`else
      check("add_127_1", last_data, 8'h80);
`endif
      do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd9);
      do_cmd(3'd4, 8'd0);
      check("dup_9", last_data, 9);

      // Randomized commands, biased towards PUSH so the stack reaches both limits
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: op = 3'd0;
            4, 8:       op = 3'd1;
            5:          op = 3'd2;
            6:          op = 3'd3;
            7:          op = 3'd4;
            default:    op = 3'($urandom_range(5, 7));
         endcase
         do_cmd(op, 8'($urandom_range(0, 255)));
      end

      // Reset in the middle of an ADD, during its second pop
      while (ref_q.size() > 0) do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd40);
      do_cmd(3'd0, 8'd40);
      do_cmd(3'd3, 8'd0);
      do_cmd(3'd0, 8'd4);
      do_cmd(3'd0, 8'd6);
      @(negedge Clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd2;
      bus.cmd_data  = '0;
      @(negedge Clock);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge Clock);
      check("midop_pop2_strobe", stk_pop, 1);
      #1 reset = 1'b1;
      #1;
      check("midop_pop_drop", stk_pop, 0);
      check("midop_push_low", stk_push, 0);
      check("midop_count", count, 0);
      check("midop_flags", {flag_z, flag_s}, 0);
      @(negedge Clock);
      reset = 1'b0;
      ref_q.delete();
      ref_z = 0;
      ref_s = 0;
      @(negedge Clock);
      check("midop_ready", bus.cmd_ready, 1);
      check("midop_rsp_valid", bus.rsp_valid, 0);
      check("midop_stack_empty", mem.size(), 0);
      do_cmd(3'd1, 8'd0);
      do_cmd(3'd0, 8'd200);
      do_cmd(3'd4, 8'd0);
      do_cmd(3'd2, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
